// File: rtl/ps2_tx.sv
// -----------------------------------------------------------------------------
// ps2_tx : PS/2 host-to-device transmitter.
//
// Sends one command byte to the keyboard over the shared PS/2 clock/data pair.
// Both lines are open-drain. This block only asserts a "pull low" enable per
// line; the board-level tristate sits outside. It runs on the system clock.
//
// Frame: start(0), data[0..7] LSB first, odd parity, stop(1), device ACK(0).
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   tx_valid     request to send tx_data
//   tx_data      command byte, captured on accept (tx_valid && tx_ready)
//   tx_ready     high only while idle
//   ps2_clk_in   raw PS/2 clock line (asynchronous)
//   ps2_data_in  raw PS/2 data line (asynchronous)
//   ps2_clk_oe   1 = pull PS/2 clock low, 0 = release
//   ps2_data_oe  1 = pull PS/2 data low, 0 = release
//   busy         high from accept until the return to idle
//   done         one-cycle pulse: byte sent and device ACK seen
//   err          one-cycle pulse: timeout or missing ACK
// -----------------------------------------------------------------------------
module ps2_tx #(
   parameter int INHIBIT_CYCLES = 5000,
   parameter int TIMEOUT_CYCLES = 750000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       tx_valid,
   input  logic [7:0] tx_data,
   output logic       tx_ready,
   input  logic       ps2_clk_in,
   input  logic       ps2_data_in,
   output logic       ps2_clk_oe,
   output logic       ps2_data_oe,
   output logic       busy,
   output logic       done,
   output logic       err
);

   // One counter serves both the inhibit interval and the transfer timeout,
   // so it is sized for the larger of the two limits.
   localparam int MAX_CYC = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
   localparam int CNT_W   = $clog2(MAX_CYC + 1);

   localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
   localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_INHIBIT,
      S_REQ,
      S_SHIFT,
      S_ACK_DONE,
      S_FAIL
   } state_t;

   state_t           state, state_n;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic [3:0]       bit_idx, bit_idx_n;
   logic             tx_ready_q, tx_ready_n;
   logic             busy_q, busy_n;
   logic             clk_oe_q, clk_oe_n;
   logic             data_oe_q, data_oe_n;
   logic             done_q, done_n;
   logic             err_q, err_n;
   logic             load;

   logic [7:0]       data_q;
   logic             par_q;

   // Synchronizer chains: _p0/_p1 are the two metastability flops, clk_p2
   // holds the previous synchronized clock for edge detection.
   logic clk_p0, clk_p1, clk_p2;
   logic data_p0, data_p1;
   logic clk_fall;

   // Odd parity: the parity bit makes the total count of ones odd.
   function automatic logic odd_parity(input logic [7:0] d);
      return ~(^d);
   endfunction

   // ---- stage p0/p1: input synchronizers, p2: previous clock sample ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         clk_p0  <= 1'b1;
         clk_p1  <= 1'b1;
         clk_p2  <= 1'b1;
         data_p0 <= 1'b1;
         data_p1 <= 1'b1;
      end else begin
         clk_p0  <= ps2_clk_in;
         clk_p1  <= clk_p0;
         clk_p2  <= clk_p1;
         data_p0 <= ps2_data_in;
         data_p1 <= data_p0;
      end
   end

   assign clk_fall = clk_p2 & ~clk_p1;

   // Byte and parity are payload only; they need no reset because they are
   // always loaded before being used.
   always_ff @(posedge clk) begin
      if (load) begin
         data_q <= tx_data;
         par_q  <= odd_parity(tx_data);
      end
   end

   // State and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         cnt        <= '0;
         bit_idx    <= '0;
         tx_ready_q <= 1'b1;
         busy_q     <= 1'b0;
         clk_oe_q   <= 1'b0;
         data_oe_q  <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state      <= state_n;
         cnt        <= cnt_n;
         bit_idx    <= bit_idx_n;
         tx_ready_q <= tx_ready_n;
         busy_q     <= busy_n;
         clk_oe_q   <= clk_oe_n;
         data_oe_q  <= data_oe_n;
         done_q     <= done_n;
         err_q      <= err_n;
      end
   end

   // Next-state and next-output logic. Outputs are computed for the state
   // being entered so that every output comes straight from a flop.
   always_comb begin
      state_n   = state;
      cnt_n     = cnt;
      bit_idx_n = bit_idx;
      clk_oe_n  = clk_oe_q;
      data_oe_n = data_oe_q;
      done_n    = 1'b0;
      err_n     = 1'b0;
      load      = 1'b0;

      unique case (state)
         S_IDLE: begin
            clk_oe_n  = 1'b0;
            data_oe_n = 1'b0;
            if (tx_valid) begin
               load      = 1'b1;
               state_n   = S_INHIBIT;
               cnt_n     = '0;
               clk_oe_n  = 1'b1;
               // The start bit goes out in the last inhibit cycle.
               data_oe_n = (INH_LAST == '0);
            end
         end

         S_INHIBIT: begin
            if (cnt == INH_LAST) begin
               state_n   = S_REQ;
               cnt_n     = '0;
               clk_oe_n  = 1'b0;
               data_oe_n = 1'b1;
            end else begin
               cnt_n     = cnt + CNT_ONE;
               data_oe_n = ((cnt + CNT_ONE) == INH_LAST);
            end
         end

         S_REQ: begin
            // Timeout counting starts at 0 here; the limit is reached on the
            // edge that enters FAIL.
            if (cnt == TO_LAST) begin
               state_n   = S_FAIL;
               clk_oe_n  = 1'b0;
               data_oe_n = 1'b0;
               err_n     = 1'b1;
            end else begin
               state_n   = S_SHIFT;
               cnt_n     = cnt + CNT_ONE;
               bit_idx_n = '0;
            end
         end

         S_SHIFT: begin
            cnt_n = cnt + CNT_ONE;
            // Timeout has priority over a clock edge seen in the same cycle.
            if (cnt == TO_LAST) begin
               state_n   = S_FAIL;
               clk_oe_n  = 1'b0;
               data_oe_n = 1'b0;
               err_n     = 1'b1;
            end else if (clk_fall) begin
               // bit_idx holds the number of falling edges already seen.
               bit_idx_n = bit_idx + 4'd1;
               if (bit_idx < 4'd8) begin
                  data_oe_n = ~data_q[bit_idx[2:0]];
               end else if (bit_idx == 4'd8) begin
                  data_oe_n = ~par_q;
               end else if (bit_idx == 4'd9) begin
                  data_oe_n = 1'b0;
               end else if (!data_p1) begin
                  state_n = S_ACK_DONE;
               end else begin
                  state_n   = S_FAIL;
                  clk_oe_n  = 1'b0;
                  data_oe_n = 1'b0;
                  err_n     = 1'b1;
               end
            end
         end

         S_ACK_DONE: begin
            cnt_n = cnt + CNT_ONE;
            if (cnt == TO_LAST) begin
               state_n   = S_FAIL;
               clk_oe_n  = 1'b0;
               data_oe_n = 1'b0;
               err_n     = 1'b1;
            end else if (clk_p1 && data_p1) begin
               // Device has released both lines: ACK complete.
               state_n = S_IDLE;
               done_n  = 1'b1;
            end
         end

         S_FAIL: begin
            state_n   = S_IDLE;
            clk_oe_n  = 1'b0;
            data_oe_n = 1'b0;
         end

         default: begin
            state_n   = S_IDLE;
            clk_oe_n  = 1'b0;
            data_oe_n = 1'b0;
         end
      endcase

      tx_ready_n = (state_n == S_IDLE);
      busy_n     = (state_n != S_IDLE);
   end

   assign tx_ready    = tx_ready_q;
   assign busy        = busy_q;
   assign ps2_clk_oe  = clk_oe_q;
   assign ps2_data_oe = data_oe_q;
   assign done        = done_q;
   assign err         = err_q;

endmodule

// File: tb/tb_ps2_tx.sv
// -----------------------------------------------------------------------------
// tb_ps2_tx : bench for ps2_tx with a simple PS/2 device model.
// Lines are modelled as wired-AND of host and device pull-downs.
// -----------------------------------------------------------------------------
module tb_ps2_tx;

   localparam int INH  = 10;
   localparam int TMO  = 4000;
   localparam int HALF = 40;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       tx_valid = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic       tx_ready, ps2_clk_oe, ps2_data_oe, busy, done, err;
   logic       ps2_clk_in, ps2_data_in;
   logic       dev_clk_low = 1'b0;
   logic       dev_data_low = 1'b0;

   assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low);
   assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

   ps2_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .tx_valid   (tx_valid),
      .tx_data    (tx_data),
      .tx_ready   (tx_ready),
      .ps2_clk_in (ps2_clk_in),
      .ps2_data_in(ps2_data_in),
      .ps2_clk_oe (ps2_clk_oe),
      .ps2_data_oe(ps2_data_oe),
      .busy       (busy),
      .done       (done),
      .err        (err)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Pulse and inhibit monitor.
   int   mon_done = 0, mon_err = 0, mon_both = 0, mon_consec = 0, mon_inh_bad = 0;
   int   run = 0, last_run = 0;
   logic prev_pulse = 1'b0;

   always @(negedge clk) begin
      if (done === 1'b1) mon_done = mon_done + 1;
      if (err === 1'b1) mon_err = mon_err + 1;
      if (done === 1'b1 && err === 1'b1) mon_both = mon_both + 1;
      if (prev_pulse && (done === 1'b1 || err === 1'b1)) mon_consec = mon_consec + 1;
      prev_pulse = (done === 1'b1) || (err === 1'b1);
      if (ps2_clk_oe === 1'b1) begin
         run = run + 1;
         if (ps2_data_oe !== (run == INH)) mon_inh_bad = mon_inh_bad + 1;
      end else if (run != 0) begin
         last_run = run;
         run = 0;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total = total + 1;
      if (act !== exp) begin
         bad = bad + 1;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] d);
      @(negedge clk);
      tx_data  = d;
      tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
      tx_data  = ~d;  // must not affect the frame in flight
      check($sformatf("accept_%02h", d), {30'd0, busy, tx_ready}, 32'b10);
   endtask

   task automatic wait_idle(input string name);
      int n;
      n = 0;
      while (!(tx_ready === 1'b1 && busy === 1'b0) && n < 300) begin
         @(negedge clk);
         n++;
      end
      check(name, {31'd0, (n < 300)}, 32'd1);
      @(negedge clk);
   endtask

   task automatic dev_wait_req(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 500; i++) begin
         @(negedge clk);
         if (ps2_clk_in === 1'b1 && ps2_data_in === 1'b0) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   // One device clock pulse; data sampled at the rising edge.
   task automatic dev_bit(output logic s);
      dev_clk_low = 1'b1;
      repeat (HALF) @(negedge clk);
      dev_clk_low = 1'b0;
      s = ps2_data_in;
      repeat (HALF) @(negedge clk);
   endtask

   // bits[0]=start, [1..8]=data LSB first, [9]=parity, [10]=stop
   task automatic dev_frame(input logic ack, output logic [10:0] bits, output bit ok);
      logic s;
      bits = '0;
      dev_wait_req(ok);
      if (!ok) return;
      repeat (HALF) @(negedge clk);
      bits[0] = ps2_data_in;
      for (int i = 1; i <= 10; i++) begin
         dev_bit(s);
         bits[i] = s;
      end
      if (ack) dev_data_low = 1'b1;
      repeat (5) @(negedge clk);
      dev_clk_low = 1'b1;
      repeat (HALF) @(negedge clk);
      dev_clk_low = 1'b0;
      repeat (10) @(negedge clk);
      dev_data_low = 1'b0;
   endtask

   typedef struct {
      logic [7:0]  data;
      logic        ack;
      logic [10:0] exp_bits;
      int          exp_done;
      int          exp_err;
   } vec_t;

   vec_t        vecs[5];
   logic [10:0] got, got2;
   bit          ok, ok2;
   int          d0, e0, n, k;
   logic        s;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // {stop, parity, data, start} computed by hand
      vecs[0] = '{8'hED, 1'b1, 11'h7DA, 1, 0};
      vecs[1] = '{8'h00, 1'b1, 11'h600, 1, 0};
      vecs[2] = '{8'h80, 1'b1, 11'h500, 1, 0};
      vecs[3] = '{8'hFF, 1'b1, 11'h7FE, 1, 0};
      vecs[4] = '{8'h5A, 1'b0, 11'h6B4, 0, 1};

      repeat (3) @(negedge clk);
      check("reset_outputs", {26'd0, tx_ready, busy, ps2_clk_oe, ps2_data_oe, done, err}, 32'b100000);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);

      // Table-driven frames
      for (int v = 0; v < 5; v++) begin
         d0 = mon_done;
         e0 = mon_err;
         fork
            send_byte(vecs[v].data);
            dev_frame(vecs[v].ack, got, ok);
         join
         check($sformatf("req_%0d", v), {31'd0, ok}, 32'd1);
         wait_idle($sformatf("idle_%0d", v));
         check($sformatf("bits_%0d", v), {21'd0, got}, {21'd0, vecs[v].exp_bits});
         check($sformatf("done_%0d", v), mon_done - d0, vecs[v].exp_done);
         check($sformatf("err_%0d", v), mon_err - e0, vecs[v].exp_err);
         check($sformatf("oe_%0d", v), {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
         check($sformatf("inhibit_len_%0d", v), last_run, INH);
      end

      // Back-to-back 0x01 then 0xFF with tx_valid held
      d0 = mon_done;
      e0 = mon_err;
      fork
         begin
            dev_frame(1'b1, got, ok);
            dev_frame(1'b1, got2, ok2);
         end
         begin
            @(negedge clk);
            tx_data  = 8'h01;
            tx_valid = 1'b1;
            @(negedge clk);
            check("b2b_accept1", {31'd0, busy}, 32'd1);
            tx_data = 8'hFF;
            n = 0;
            while (done !== 1'b1 && n < 3000) begin
               @(negedge clk);
               n++;
            end
            check("b2b_done1_seen", {31'd0, (n < 3000)}, 32'd1);
            check("b2b_idle_gap", {30'd0, tx_ready, ps2_clk_oe}, 32'b10);
            @(negedge clk);
            check("b2b_second_inhibit", {30'd0, busy, ps2_clk_oe}, 32'b11);
            tx_valid = 1'b0;
         end
      join
      wait_idle("b2b_idle");
      check("b2b_req", {30'd0, ok, ok2}, 32'b11);
      check("b2b_bits1", {21'd0, got}, 32'h402);
      check("b2b_bits2", {21'd0, got2}, 32'h7FE);
      check("b2b_done", mon_done - d0, 2);
      check("b2b_err", mon_err - e0, 0);

      // Device never clocks: timeout
      d0 = mon_done;
      e0 = mon_err;
      send_byte(8'h3C);
      n = 0;
      while (ps2_clk_oe !== 1'b0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("to_req_seen", {31'd0, (n < 100)}, 32'd1);
      check("to_req_data", {31'd0, ps2_data_oe}, 32'd1);
      k = 0;
      while (err !== 1'b1 && k < 6000) begin
         @(negedge clk);
         k++;
      end
      check("to_latency", k, TMO);
      check("to_lines", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
      @(negedge clk);
      check("to_ready", {30'd0, tx_ready, busy}, 32'b10);
      check("to_err", mon_err - e0, 1);
      check("to_done", mon_done - d0, 0);

      // Reset in the middle of SHIFT
      fork
         send_byte(8'hED);
         begin
            dev_wait_req(ok);
            repeat (HALF) @(negedge clk);
            for (int i = 0; i < 4; i++) dev_bit(s);
            dev_clk_low = 1'b1;  // 5th falling edge: bit4 of 0xED is 0
            repeat (10) @(negedge clk);
         end
      join
      check("rst_pre_state", {29'd0, busy, ps2_clk_oe, ps2_data_oe}, 32'b101);
      #2;
      rst_n = 1'b0;
      #1;
      check("rst_async", {26'd0, tx_ready, busy, ps2_clk_oe, ps2_data_oe, done, err}, 32'b100000);
      dev_clk_low = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      d0 = mon_done;
      e0 = mon_err;
      fork
         send_byte(8'hED);
         dev_frame(1'b1, got, ok);
      join
      wait_idle("rst_after_idle");
      check("rst_after_bits", {21'd0, got}, 32'h7DA);
      check("rst_after_done", mon_done - d0, 1);
      check("rst_after_err", mon_err - e0, 0);

      check("pulse_overlap", mon_both, 0);
      check("pulse_consecutive", mon_consec, 0);
      check("inhibit_data_timing", mon_inh_bad, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ps2_tx.md
Name: ps2_tx

Overview:
PS/2 host-to-device transmitter. It sends one command byte (e.g. 0xED set-LEDs, 0xFF reset) to the keyboard over the same kbd clock/data pair that the existing PS/2 receiver listens on. The lines are open-drain: the block only ever pulls a line low or releases it, and the board-level tristate sits outside the block. It runs on the fast system clock, not the divided CPU clock.

Parameters:
INHIBIT_CYCLES, 5000, system clocks that ps2_clk is held low before the start bit (100 us at 50 MHz).
TIMEOUT_CYCLES, 750000, system clocks allowed from release of clock to ACK completion (15 ms at 50 MHz).

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
tx_valid  input  1  request to send tx_data
tx_data  input  8  command byte, sampled on accept
tx_ready  output  1  high in IDLE only; accept = tx_valid && tx_ready at rising clk
ps2_clk_in  input  1  raw PS/2 clock line (asynchronous)
ps2_data_in  input  1  raw PS/2 data line (asynchronous)
ps2_clk_oe  output  1  1 = pull PS/2 clock low, 0 = release
ps2_data_oe  output  1  1 = pull PS/2 data low, 0 = release
busy  output  1  high from accept until return to IDLE
done  output  1  one-cycle pulse: byte sent and device ACK seen
err  output  1  one-cycle pulse: timeout or missing ACK

Behaviour:
- Reset: state IDLE; ps2_clk_oe=0, ps2_data_oe=0, busy=0, done=0, err=0, tx_ready=1. Reset applies immediately, at any time.
- Both inputs pass through a 2-FF synchronizer. A falling edge is defined as sync_prev=1 and sync_now=0.
- Frame: start bit (0), then 8 data bits LSB first, then an odd parity bit (total count of ones across data and parity is odd), then stop bit (1, line released), then the device ACK (device drives data low).
- IDLE: tx_ready=1 and both oe=0. On accept, tx_data and its parity bit are latched, and the state moves to INHIBIT on the next cycle. busy rises and tx_ready falls in that same cycle.
- INHIBIT: ps2_clk_oe=1 for exactly INHIBIT_CYCLES clocks. In the last of those cycles ps2_data_oe goes to 1 (start bit). Next state is REQ.
- REQ: ps2_clk_oe=0 and ps2_data_oe=1. The timeout counter starts at 0 and then counts every cycle until ACK_DONE is left.
- SHIFT: the bit index counts falling edges of the synchronized clock.
  - Falling edges 1..8 each set ps2_data_oe = ~bit[n-1] (a 1 bit releases the line, a 0 bit pulls it low).
  - Falling edge 9 sets ps2_data_oe = ~parity.
  - Falling edge 10 sets ps2_data_oe=0 (stop bit).
  - Falling edge 11 samples synchronized data: 0 goes to ACK_DONE, 1 goes to FAIL.
- ACK_DONE: wait until synchronized clock=1 and data=1, then pulse done for 1 cycle and return to IDLE.
- FAIL: release both lines, pulse err for 1 cycle, return to IDLE.
- Timeout: if the counter reaches TIMEOUT_CYCLES in REQ, SHIFT or ACK_DONE, go to FAIL. Timeout wins over an edge that occurs in the same cycle.
- done and err are never high together and never high in consecutive cycles for the same request.
- tx_valid while busy is ignored and nothing is queued. tx_data changes after accept have no effect.
- A device frame in progress when INHIBIT starts is aborted by the device, per protocol. Coordination with the receiver is handled outside this block.
- Counters are sized with $clog2 of the larger parameter and must not wrap before their limit.

Test Plan:
- Bench parameters: INHIBIT_CYCLES=10, TIMEOUT_CYCLES=4000. The device model clocks at a 40-clk half-period, samples on rising edges, and ACKs on the 11th falling edge.
- Send 0xED: ps2_clk_oe is 1 for exactly 10 cycles. The device samples start 0, data 1,0,1,1,0,1,1,1, parity 1, stop 1. done pulses once, busy falls, tx_ready=1.
- Send 0x01, then 0xFF back-to-back (tx_valid held): parity 0 and 1 respectively. Two done pulses. The second INHIBIT begins only after the first return to IDLE.
- Device omits ACK (data high at the 11th falling edge) -> err pulse, no done, both oe=0, tx_ready=1.
- Device never clocks after REQ -> err exactly TIMEOUT_CYCLES clocks after REQ entry. Both lines are released.
- Assert rst_n=0 mid-SHIFT (after the 4th bit) -> ps2_clk_oe=ps2_data_oe=0 with no clock edge, busy=0. After release, a new 0xED transfer completes normally.
